dmem_byte_ctrl: RTL
===================

# dmem_byte_ctrl

Two-port arbiter and sequencer in front of a single-port, byte-wide data RAM. It accepts load/store requests from two requesters: port 0 is the core load/store path and port 1 is the debug/DMA path. It serialises each byte, halfword or word access into 1/2/4 byte beats, assembles and extends load data, and returns one response per request. The RAM itself lives outside this block.

## Interface
Parameters:
- ADDR_W, 10, RAM byte-address width (1024 bytes).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- reqN_valid  in  1  request present, for N = 0 and 1.
- reqN_ready  out  1  request accepted this cycle.
- reqN_we  in  1  1 = store, 0 = load.
- reqN_width  in  2  access width: 00 byte, 01 half, 11 word; 10 is treated as word.
- reqN_sign  in  1  load extension: 1 = signed, 0 = zero-extend.
- reqN_addr  in  32  byte address; only the low ADDR_W bits are used.
- reqN_wdata  in  32  store data, little-endian.
- respN_valid  out  1  one-cycle completion pulse.
- respN_rdata  out  32  extended load data; 0 for stores.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_wdata  out  8  RAM write byte.
- ram_rdata  in  8  read byte, valid in the cycle after ram_en with ram_we=0.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE -> ISSUE when a request is accepted.
- ISSUE lasts N beats, where N = 1/2/4 from width. Beat k drives ram_en=1, ram_addr = addr + k modulo 2^ADDR_W, and ram_wdata = wdata[8k+7:8k].
- After the last beat, a load goes to WAIT and a store goes straight to IDLE. WAIT -> IDLE after one cycle.
- Unaligned addresses are legal. Address wrap-around at 2^ADDR_W is silent.
- Handshake: reqN_ready = (state==IDLE) & reqN_valid & grant==N. reqN_ready is combinational. A request transfers on valid&ready. A requester holds valid and all request fields stable until ready.
- All request fields are latched at accept. The latched copy drives the whole transfer.
- Arbitration is two-way round-robin. When both ports are valid, the port not granted last time wins. A single valid port always wins. After reset, last_grant=1, so port 0 wins the first tie.
- Read byte k is captured into the assembly register at byte lane k.
- Byte load result: sign ? {{24{b[7]}},b[7:0]} : zero-extended.
- Halfword load result: sign ? {{16{h[15]}},h[15:0]} : zero-extended.
- Word load result: unmodified.
- respN_valid pulses only on the port that owns the transfer. Its rdata is valid in the same cycle.
- Reset mid-transfer: the transfer aborts with no response. Bytes already written remain in RAM.

## Timing
- Reset values: all outputs 0. State = IDLE, last_grant = 1, assembly register = 0.
- Cycle 0 is the accept cycle.
- ram_en is high in cycles 1..N.
- Store: respN_valid is high in cycle N+1.
- Load: WAIT is cycle N+1; respN_valid is high in cycle N+2.
- The response cycle is an IDLE cycle, so a new request may be accepted in it. Back-to-back word stores: one accept every 5 cycles.
- ram_en is never high in IDLE or WAIT.
- A port's valid is ignored while the block is busy, even the owner's.

## Configuration
- DMEM_ARB_FIXED_PRIO_EN defined: strict priority; port 0 always wins ties and last_grant is unused.
- DMEM_ARB_FIXED_PRIO_EN undefined: round-robin as above.
- All other behaviour is identical in both builds.

## Structure
- Shared package dmem_pkg holds:
  - width constants WIDTH_BYTE=2'b00, WIDTH_HALF=2'b01, WIDTH_WORD=2'b11;
  - function beats(width) returning 1/2/4;
  - FSM state enum;
  - load-extension function shared with the core writeback path.
- One sub-module: dmem_rr_arb. It is a two-way arbiter with valid[1:0], an advance strobe, and grant[1:0]. It contains last_grant and the fixed-priority macro switch.

## Test plan
- Port 0 stores word 0xDEADBEEF to addr 0x10 -> RAM writes EF, BE, AD, DE at 0x10..0x13 in cycles 1..4; resp0_valid in cycle 5.
- Port 0 loads byte from 0x13 with sign=1 -> resp0_rdata=0xFFFFFFDE in cycle 3; with sign=0 -> 0x000000DE.
- Store half 0xA55A at addr 0x3FF -> bytes land at 0x3FF and 0x000 (wrap). Signed half load from the same address -> 0xFFFFA55A.
- Both ports request together from reset, three times in a row -> grants go 0, 1, 0. With DMEM_ARB_FIXED_PRIO_EN defined -> 0, 0, 0 while port 0 stays valid.
- Deassert rst_n during beat 2 of a word store -> all outputs 0 immediately, no response, FSM in IDLE after release, next request accepted normally.
- Word load accepted in its own response cycle after a prior store -> no idle gap; resp timing N+2 holds.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-serialising data-memory controller: access widths,
// beat count, FSM states and the load-extension helper also used by core writeback.
package dmem_pkg;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } dmemState_e;

    // Encoding 2'b10 is reserved and behaves as a word.
    function automatic logic [2:0] beats(input logic [1:0] width);
        case (width)
            WIDTH_BYTE: beats = 3'd1;
            WIDTH_HALF: beats = 3'd2;
            default:    beats = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] loadExtend(input logic [1:0]  width,
                                               input logic        sign,
                                               input logic [31:0] data);
        case (width)
            WIDTH_BYTE: loadExtend = {{24{sign & data[7]}}, data[7:0]};
            WIDTH_HALF: loadExtend = {{16{sign & data[15]}}, data[15:0]};
            default:    loadExtend = data;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_ctrl_if.sv
// One requester port of dmem_byte_ctrl: request handshake plus completion pulse.
interface dmem_byte_ctrl_if;

    logic        valid;
    logic        ready;
    logic        we;
    logic [1:0]  width;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    modport master (
        output valid, we, width, sign, addr, wdata,
        input  ready, resp_valid, resp_rdata
    );

    modport slave (
        input  valid, we, width, sign, addr, wdata,
        output ready, resp_valid, resp_rdata
    );

endinterface

// File: rtl/dmem_rr_arb.sv
// Two-way request arbiter. Round-robin by default; defining DMEM_ARB_FIXED_PRIO_EN
// selects strict priority to port 0 and drops the last-grant state.
module dmem_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

`ifdef DMEM_ARB_FIXED_PRIO_EN

    logic unusedArbInputs;
    assign unusedArbInputs = ^{clk, rst_n, advance};

    always_comb begin
        grant = 2'b00;
        if (valid[0]) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end
    end

`else

    logic lastGrantQ;

    // On a tie the port that did not win last time is favoured.
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = lastGrantQ ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastGrantQ <= 1'b1;
        end else if (advance) begin
            lastGrantQ <= grant[1];
        end
    end

`endif

endmodule

// File: rtl/dmem_byte_ctrl.sv
// Arbitrates two load/store ports onto a byte-wide single-port RAM, one byte beat per cycle.
// Arbitration mode is selected by DMEM_ARB_FIXED_PRIO_EN (see dmem_rr_arb).
module dmem_byte_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_byte_ctrl_if.slave   req0,
    dmem_byte_ctrl_if.slave   req1,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    dmemState_e        stateQ, stateD;
    logic [1:0]        beatQ, beatD;
    logic              ownerQ, ownerD;
    logic              weQ, weD;
    logic              signQ, signD;
    logic [1:0]        widthQ, widthD;
    logic [ADDR_W-1:0] addrQ, addrD;
    logic [31:0]       wdataQ, wdataD;
    logic [31:0]       asmQ, asmD, asmMerged;
    logic              rdPendQ, rdPendD;
    logic [1:0]        rdLaneQ, rdLaneD;
    logic [1:0]        respValidQ, respValidD;
    logic [31:0]       respRdataQ, respRdataD;

    logic [1:0]        reqValid;
    logic [1:0]        grant;
    logic              accept;
    logic              lastBeat;
    logic              selWe;
    logic              selSign;
    logic [1:0]        selWidth;
    logic [31:0]       selAddr;
    logic [31:0]       selWdata;

    logic unusedAddrBits;
    assign unusedAddrBits = ^{req0.addr[31:ADDR_W], req1.addr[31:ADDR_W]};

    assign reqValid = {req1.valid, req0.valid};
    assign accept   = (stateQ == StIdle) && (grant != 2'b00);

    dmem_rr_arb uArb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (reqValid),
        .advance(accept),
        .grant  (grant)
    );

    // Grant already implies valid, so ready only needs the idle qualifier.
    assign req0.ready = (stateQ == StIdle) && grant[0];
    assign req1.ready = (stateQ == StIdle) && grant[1];

    assign selWe    = grant[1] ? req1.we    : req0.we;
    assign selSign  = grant[1] ? req1.sign  : req0.sign;
    assign selWidth = grant[1] ? req1.width : req0.width;
    assign selAddr  = grant[1] ? req1.addr  : req0.addr;
    assign selWdata = grant[1] ? req1.wdata : req0.wdata;

    assign lastBeat = ({1'b0, beatQ} == (beats(widthQ) - 3'd1));

    // Read data trails its beat by one cycle; fold it in before it is registered.
    always_comb begin
        asmMerged = asmQ;
        if (rdPendQ) begin
            asmMerged[{rdLaneQ, 3'b000} +: 8] = ram_rdata;
        end
    end

    always_comb begin
        stateD     = stateQ;
        beatD      = beatQ;
        ownerD     = ownerQ;
        weD        = weQ;
        signD      = signQ;
        widthD     = widthQ;
        addrD      = addrQ;
        wdataD     = wdataQ;
        asmD       = asmMerged;
        rdPendD    = (stateQ == StIssue) && !weQ;
        rdLaneD    = beatQ;
        respValidD = 2'b00;
        respRdataD = '0;

        case (stateQ)
            StIdle: begin
                if (accept) begin
                    stateD = StIssue;
                    beatD  = '0;
                    ownerD = grant[1];
                    weD    = selWe;
                    signD  = selSign;
                    widthD = selWidth;
                    addrD  = selAddr[ADDR_W-1:0];
                    wdataD = selWdata;
                    asmD   = '0;
                end
            end
            StIssue: begin
                if (lastBeat) begin
                    beatD = '0;
                    if (weQ) begin
                        stateD     = StIdle;
                        respValidD = ownerQ ? 2'b10 : 2'b01;
                    end else begin
                        stateD = StWait;
                    end
                end else begin
                    beatD = beatQ + 2'd1;
                end
            end
            StWait: begin
                stateD     = StIdle;
                respValidD = ownerQ ? 2'b10 : 2'b01;
                respRdataD = loadExtend(widthQ, signQ, asmMerged);
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ     <= StIdle;
            beatQ      <= '0;
            ownerQ     <= 1'b0;
            weQ        <= 1'b0;
            signQ      <= 1'b0;
            widthQ     <= WIDTH_BYTE;
            addrQ      <= '0;
            wdataQ     <= '0;
            asmQ       <= '0;
            rdPendQ    <= 1'b0;
            rdLaneQ    <= '0;
            respValidQ <= 2'b00;
            respRdataQ <= '0;
        end else begin
            stateQ     <= stateD;
            beatQ      <= beatD;
            ownerQ     <= ownerD;
            weQ        <= weD;
            signQ      <= signD;
            widthQ     <= widthD;
            addrQ      <= addrD;
            wdataQ     <= wdataD;
            asmQ       <= asmD;
            rdPendQ    <= rdPendD;
            rdLaneQ    <= rdLaneD;
            respValidQ <= respValidD;
            respRdataQ <= respRdataD;
        end
    end

    // RAM strobes are decoded from state so reset forces them low at once.
    assign ram_en    = (stateQ == StIssue);
    assign ram_we    = ram_en && weQ;
    assign ram_addr  = ram_en ? (addrQ + ADDR_W'(beatQ)) : '0;
    assign ram_wdata = ram_we ? wdataQ[{beatQ, 3'b000} +: 8] : 8'h00;

    assign req0.resp_valid = respValidQ[0];
    assign req1.resp_valid = respValidQ[1];
    assign req0.resp_rdata = respValidQ[0] ? respRdataQ : 32'h0;
    assign req1.resp_rdata = respValidQ[1] ? respRdataQ : 32'h0;

endmodule
